lcd_timing_gen: RTL and testbench
=================================

# lcd_timing_gen

Video timing source for the 480x272 RGB LCD path. It generates the hs/vs/de stream that the display selector consumes, and pulls RGB565 pixels from the SDRAM read FIFO so that they arrive aligned with de. It sits between the SDRAM read-side FIFO and the display selector input, one instance per video source, all running in the LCD pixel clock domain.

## Interface
Parameters:
- H_SYNC, 41: hsync width in clocks
- H_BP, 2: horizontal back porch
- H_ACT, 480: active pixels per line
- H_FP, 2: horizontal front porch
- V_SYNC, 10: vsync width in lines
- V_BP, 2: vertical back porch
- V_ACT, 272: active lines
- V_FP, 2: vertical front porch
- SYNC_POL, 0: sync active level (0 = active-low)
- CNT_W, 11: h/v counter width

Ports:
- clk  in  1  LCD pixel clock
- rst  in  1  reset, asynchronous, active-high
- rd_req  out  1  FIFO read request, 1-cycle read latency
- rd_data  in  16  RGB565 word from FIFO, valid the cycle after rd_req
- fifo_empty  in  1  FIFO empty flag, sampled with rd_req
- out_hs  out  1  horizontal sync
- out_vs  out  1  vertical sync
- out_de  out  1  data enable
- out_data  out  16  RGB565 pixel, 0 when out_de=0
- pix_x  out  CNT_W  active column, valid while out_de=1
- pix_y  out  CNT_W  active line, valid while out_de=1
- frame_start  out  1  one-cycle pulse at frame origin
- underflow  out  1  sticky FIFO-underflow flag, cleared at frame_start

## Operation
- Stage 0 holds the counters h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1.
  - H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP = 525.
  - V_TOTAL = V_SYNC+V_BP+V_ACT+V_FP = 286.
- Counter stepping:
  - h_cnt increments every clock and wraps to 0 at H_TOTAL-1.
  - v_cnt increments on each h wrap and wraps to 0 at V_TOTAL-1 while h wraps.
- Regions (h shown; v is analogous on v_cnt):
  - sync: [0, H_SYNC)
  - back porch: [H_SYNC, H_SYNC+H_BP)
  - active: [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT)
  - front porch: the remainder
- rd_req is combinational from stage 0: it is 1 when both h and v are in the active region. There is no other gating; the FIFO read must not be stalled.
- Stage 1 registers the following from stage 0 so that they line up with rd_data:
  - hs_raw, vs_raw, de_raw
  - pix_x = h_cnt-(H_SYNC+H_BP)
  - pix_y = v_cnt-(V_SYNC+V_BP)
- Stage 1 also registers rd_req&fifo_empty as a miss flag.
- Output mapping:
  - out_hs = hs_raw XNOR SYNC_POL.
  - out_vs is driven the same way.
  - out_de = de_raw.
  - out_data = rd_data when de_raw=1 and miss=0; otherwise 0.
- frame_start is a registered pulse that is high for the single stage-1 cycle derived from h_cnt=0, v_cnt=0.
- underflow is set in any cycle where stage 0 has rd_req=1 and fifo_empty=1.
  - It is cleared in the cycle frame_start is asserted.
  - Set wins over clear if both happen together.
- The counters free-run. There is no enable and no resync input.

## Timing
- Reset values, all asynchronous:
  - h_cnt=0, v_cnt=0
  - out_hs and out_vs at the inactive level (1 when SYNC_POL=0)
  - out_de=0, out_data=0, pix_x=0, pix_y=0
  - frame_start=0, underflow=0
  - rd_req=0 while rst=1
- Latency:
  - Stage 0 to all outputs (sync, de, data, pix_x/y, frame_start) is 1 cycle.
  - rd_req leads out_de by exactly 1 cycle.
  - The rd_req pulse count equals the out_de count on every line: 480 per active line, 0 on blank lines.
- First cycle after reset release: stage 0 is at (0,0), and stage 1 shows frame_start=1 and sync active one clock later.
- Per line: out_hs is active for 41 clocks, out_de is high for 480 contiguous clocks starting 43 clocks after the hs leading edge, and the period is 525.
- Per frame: out_vs is active for 10 lines (5250 clocks), there are 272 de lines, and the frame period is 150150 clocks.
- Reset asserted mid-line or mid-frame: all outputs go to reset values immediately and rd_req drops to 0. Any FIFO word already requested is ignored, and the FIFO owner must flush it.
- Wrap boundary: the cycle after (H_TOTAL-1, V_TOTAL-1) is (0,0). The last pixel of line 271 is followed by front porch with no extra de.

## Structure
- Shared package lcd_pkg holds:
  - the default timing constants (H_* and V_* for 480x272)
  - the derived H_TOTAL, V_TOTAL, H_ACT_START and V_ACT_START
  - an RGB565 pixel typedef
- One natural sub-module, lcd_axis_cnt, is instantiated twice (h and v). It contains:
  - a counter with parameters SYNC, BP, ACT, FP
  - an inc input and a wrap output
  - sync and active region outputs
- The top level chains h wrap into v inc and owns stage 1 and the underflow logic.

## Test plan
- Reset release → out_hs=1, out_vs=1, out_de=0, out_data=0. The next stage-1 cycle has frame_start=1 with hs and vs low.
- Count clocks between hs falling edges → exactly 525. Over one frame → 286 lines and 272 lines containing de, each with 480 de clocks starting 43 clocks after hs falls.
- FIFO model with 1-cycle latency returning pix_y*480+pix_x → out_data matches that value on every de cycle, and rd_req precedes every de by one cycle.
- Force fifo_empty=1 for pixel (10,5) → out_data=0 at that pixel and underflow=1 until the next frame_start. With fifo_empty=1 also on the frame's first active pixel, underflow stays 1.
- Assert rst at h_cnt=300, v_cnt=100 for 3 clocks → outputs go to reset values within the same cycle and rd_req=0. After release, timing restarts from (0,0) with frame_start.
- SYNC_POL=1 build → hs and vs are active-high with identical widths and positions. de and data are unchanged.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared timing constants and pixel type for the 480x272 RGB LCD path.
package lcd_pkg;

  // Default panel timing for the 480x272 display, in clocks (h) and lines (v).
  localparam int H_SYNC_DEF = 41;
  localparam int H_BP_DEF   = 2;
  localparam int H_ACT_DEF  = 480;
  localparam int H_FP_DEF   = 2;
  localparam int V_SYNC_DEF = 10;
  localparam int V_BP_DEF   = 2;
  localparam int V_ACT_DEF  = 272;
  localparam int V_FP_DEF   = 2;
  localparam int CNT_W_DEF  = 11;

  // Derived totals and first active positions for the default timing.
  localparam int H_TOTAL     = H_SYNC_DEF + H_BP_DEF + H_ACT_DEF + H_FP_DEF;
  localparam int V_TOTAL     = V_SYNC_DEF + V_BP_DEF + V_ACT_DEF + V_FP_DEF;
  localparam int H_ACT_START = H_SYNC_DEF + H_BP_DEF;
  localparam int V_ACT_START = V_SYNC_DEF + V_BP_DEF;

  // One RGB565 pixel as delivered by the SDRAM read FIFO.
  typedef logic [15:0] rgb565_t;

endpackage

// File: rtl/lcd_axis_cnt.sv
// One timing axis: free-running position counter with sync/active region decode.
// The horizontal instance steps every clock; the vertical one steps on h wrap.
module lcd_axis_cnt
  import lcd_pkg::*;
#(
  parameter int SYNC  = H_SYNC_DEF,
  parameter int BP    = H_BP_DEF,
  parameter int ACT   = H_ACT_DEF,
  parameter int FP    = H_FP_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             in_sync,
  output logic             in_act
);

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(SYNC + BP + ACT + FP - 1);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] ACT_BEG  = CNT_W'(SYNC + BP);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(SYNC + BP + ACT);

  // wrap is only meaningful when the axis is actually stepping this cycle.
  assign wrap    = inc && (cnt == LAST);
  assign in_sync = (cnt < SYNC_END);
  assign in_act  = (cnt >= ACT_BEG) && (cnt < ACT_END);

  // Step the position, returning to 0 after the last position of the axis.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD video timing source: stage 0 counters drive the FIFO read request,
// stage 1 registers sync/de/position so they line up with the returned word.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int H_ACT    = H_ACT_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int V_ACT    = V_ACT_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic             rd_req,
  input  logic [15:0]      rd_data,
  input  logic             fifo_empty,
  output logic             out_hs,
  output logic             out_vs,
  output logic             out_de,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] H_START = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_START = CNT_W'(V_SYNC + V_BP);

  // Stage 0: horizontal and vertical positions.
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap;
  logic             h_sync, v_sync;
  logic             h_act, v_act;
  logic             at_origin;

  // Stage 1: timing aligned with the FIFO word requested in stage 0.
  logic             hs_raw_reg, vs_raw_reg, de_raw_reg;
  logic             miss_reg;
  logic             frame_start_reg;
  logic [CNT_W-1:0] pix_x_reg, pix_y_reg;
  logic             underflow_reg;
  rgb565_t          pixel;

  lcd_axis_cnt #(
    .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP), .CNT_W(CNT_W)
  ) u_h_cnt (
    .clk(clk), .rst(rst), .inc(1'b1),
    .cnt(h_cnt), .wrap(h_wrap), .in_sync(h_sync), .in_act(h_act)
  );

  lcd_axis_cnt #(
    .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP), .CNT_W(CNT_W)
  ) u_v_cnt (
    .clk(clk), .rst(rst), .inc(h_wrap),
    .cnt(v_cnt), .wrap(v_wrap), .in_sync(v_sync), .in_act(v_act)
  );

  // Reset parks both counters in the sync region, so rd_req is already 0 there
  // and no extra gating is needed; the read must never be stalled.
  assign rd_req    = h_act && v_act;
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);

  // Stage 1 pipeline: one-cycle delayed timing, position and FIFO-miss flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_raw_reg      <= 1'b0;
      vs_raw_reg      <= 1'b0;
      de_raw_reg      <= 1'b0;
      miss_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
    end else begin
      hs_raw_reg      <= h_sync;
      vs_raw_reg      <= v_sync;
      de_raw_reg      <= rd_req;
      miss_reg        <= rd_req && fifo_empty;
      frame_start_reg <= at_origin;
      pix_x_reg       <= h_cnt - H_START;
      pix_y_reg       <= v_cnt - V_START;
    end
  end

  // Sticky underflow: a missed read sets it, frame origin clears it, set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_reg <= 1'b0;
    end else if (rd_req && fifo_empty) begin
      underflow_reg <= 1'b1;
    end else if (at_origin) begin
      underflow_reg <= 1'b0;
    end
  end

  // A missed word is blanked rather than passing stale FIFO output.
  assign pixel       = (de_raw_reg && !miss_reg) ? rgb565_t'(rd_data) : rgb565_t'(16'h0000);
  assign out_hs      = ~(hs_raw_reg ^ SYNC_POL);
  assign out_vs      = ~(vs_raw_reg ^ SYNC_POL);
  assign out_de      = de_raw_reg;
  assign out_data    = pixel;
  assign pix_x       = pix_x_reg;
  assign pix_y       = pix_y_reg;
  assign frame_start = frame_start_reg;
  assign underflow   = underflow_reg;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen using a reduced panel geometry so that
// several whole frames fit in a short run. Expected values come from the frame
// position derived arithmetically from the number of clocks since reset release.
module tb_lcd_timing_gen;

  localparam int HS = 3, HB = 2, HA = 16, HF = 2;
  localparam int VS = 2, VB = 1, VA = 8,  VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FRAME = HT * VT;
  localparam int H_AS = HS + HB;
  localparam int V_AS = VS + VB;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   rd_data;
  logic          fifo_empty;

  logic          rd_req, out_hs, out_vs, out_de, frame_start, underflow;
  logic [15:0]   out_data;
  logic [CW-1:0] pix_x, pix_y;

  logic          rd_req2, out_hs2, out_vs2, out_de2, frame_start2, underflow2;
  logic [15:0]   out_data2;
  logic [CW-1:0] pix_x2, pix_y2;

  int  compared = 0;
  int  mismatched = 0;
  int  k;
  bit  prev_empty;
  bit  uf_model;
  bit  prev_hs;
  int  last_fall;
  int  req_acc, req_done, de_acc;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
    .SYNC_POL(1'b0), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_data(rd_data), .fifo_empty(fifo_empty),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .out_data(out_data),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .underflow(underflow)
  );

  lcd_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
    .SYNC_POL(1'b1), .CNT_W(CW)
  ) dut_pos (
    .clk(clk), .rst(rst), .rd_req(rd_req2), .rd_data(rd_data), .fifo_empty(fifo_empty),
    .out_hs(out_hs2), .out_vs(out_vs2), .out_de(out_de2), .out_data(out_data2),
    .pix_x(pix_x2), .pix_y(pix_y2), .frame_start(frame_start2), .underflow(underflow2)
  );

  function automatic bit is_act(input int h, input int v);
    return (h >= H_AS) && (h < H_AS + HA) && (v >= V_AS) && (v < V_AS + VA);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h (clk %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".rd_req"}, rd_req, 0);
    check({tag, ".hs"}, out_hs, 1);
    check({tag, ".vs"}, out_vs, 1);
    check({tag, ".de"}, out_de, 0);
    check({tag, ".data"}, out_data, 0);
    check({tag, ".pix_x"}, pix_x, 0);
    check({tag, ".pix_y"}, pix_y, 0);
    check({tag, ".frame_start"}, frame_start, 0);
    check({tag, ".underflow"}, underflow, 0);
    check({tag, ".hs_pos"}, out_hs2, 0);
    check({tag, ".vs_pos"}, out_vs2, 0);
  endtask

  task automatic model_restart();
    k = 0;
    fifo_empty = 1'b0;
    prev_empty = 1'b0;
    uf_model = 1'b0;
    prev_hs = 1'b1;
    last_fall = -1;
    req_acc = 0;
    req_done = 0;
    de_acc = 0;
  endtask

  // One clock: serve the FIFO word requested last cycle, choose this cycle's
  // empty flag, then compare every output against the position model.
  task automatic run_cycle(input int mode);
    int hp, vp, h0, v0;
    bit act_p, act0, miss_p, emp;
    logic [15:0] exp_data;
    @(posedge clk);
    #1;
    k++;
    hp = (k - 1) % HT;
    vp = ((k - 1) / HT) % VT;
    h0 = k % HT;
    v0 = (k / HT) % VT;
    act_p = is_act(hp, vp);
    act0 = is_act(h0, v0);
    miss_p = act_p && prev_empty;
    if (miss_p) uf_model = 1'b1;
    else if (hp == 0 && vp == 0) uf_model = 1'b0;
    exp_data = (act_p && !miss_p) ? 16'((vp - V_AS) * HA + (hp - H_AS)) : 16'h0000;
    rd_data = (act_p && !miss_p) ? exp_data : 16'($urandom);
    emp = 1'b0;
    if (!act0) begin
      emp = ($urandom_range(3, 0) == 0);
    end else begin
      if (mode >= 1 && h0 == H_AS + 10 && v0 == V_AS + 5) emp = 1'b1;
      if (mode >= 2 && h0 == H_AS && v0 == V_AS) emp = 1'b1;
      if (mode >= 3 && $urandom_range(15, 0) == 0) emp = 1'b1;
    end
    fifo_empty = emp;
    prev_empty = emp;
    @(negedge clk);
    check("rd_req", rd_req, act0);
    check("hs", out_hs, (hp < HS) ? 0 : 1);
    check("vs", out_vs, (vp < VS) ? 0 : 1);
    check("de", out_de, act_p);
    check("data", out_data, exp_data);
    check("frame_start", frame_start, (hp == 0 && vp == 0));
    check("underflow", underflow, uf_model);
    if (act_p) begin
      check("pix_x", pix_x, hp - H_AS);
      check("pix_y", pix_y, vp - V_AS);
    end
    check("hs_pos", out_hs2, (hp < HS) ? 1 : 0);
    check("vs_pos", out_vs2, (vp < VS) ? 1 : 0);
    check("de_pos", out_de2, act_p);
    check("data_pos", out_data2, exp_data);
    if (prev_hs && !out_hs) begin
      if (last_fall >= 0) check("hs_period", k - last_fall, HT);
      last_fall = k;
    end
    prev_hs = out_hs;
    if (h0 == 0) req_acc = 0;
    req_acc += int'(rd_req);
    if (h0 == HT - 1) req_done = req_acc;
    if (hp == 0) de_acc = 0;
    de_acc += int'(out_de);
    if (hp == HT - 1) begin
      check("line_de_count", de_acc, (vp >= V_AS && vp < V_AS + VA) ? HA : 0);
      check("line_req_count", req_done, de_acc);
      $display("line y=%0d de=%0d req=%0d underflow=%0b", vp, de_acc, req_done, underflow);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    rd_data = 16'hdead;
    model_restart();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("init");
    rst = 1'b0;
    model_restart();
    #1;
    check_reset("release");

    // Frame 0 clean, 1 with a miss at (10,5), 2 adding the first pixel, 3 random.
    for (int fr = 0; fr < 4; fr++) begin
      repeat (FRAME) run_cycle(fr);
    end

    // Walk to a mid-frame active position, then hit reset for three clocks.
    n = 0;
    while (!((k % HT) == 15 && ((k / HT) % VT) == 6) && n < FRAME) begin
      run_cycle(3);
      n++;
    end
    check("reset_point_reached", (n < FRAME), 1);
    rst = 1'b1;
    #1;
    check_reset("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    model_restart();
    #1;
    check_reset("rst_release");
    repeat (2 * FRAME) run_cycle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
